// File: rtl/snake_dir_ctrl_if.sv
// Pushbutton and direction bus between the board/game core and snake_dir_ctrl.
// The master side drives the raw keys, enable and step; the slave side
// (snake_dir_ctrl) returns the committed direction and status pulses.
interface snake_dir_ctrl_if;
    logic [3:0] key_ni;
    logic       enable_i;
    logic       step_i;
    logic [1:0] dir_o;
    logic       pend_valid_o;
    logic [3:0] key_press_o;
    logic       reject_o;

    modport master (
        output key_ni,
        output enable_i,
        output step_i,
        input  dir_o,
        input  pend_valid_o,
        input  key_press_o,
        input  reject_o
    );

    modport slave (
        input  key_ni,
        input  enable_i,
        input  step_i,
        output dir_o,
        output pend_valid_o,
        output key_press_o,
        output reject_o
    );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake direction front-end: synchronises and debounces the four active-low
// pushbuttons, turns debounced presses into a buffered direction change and
// commits it to dir_o on the game-step tick, refusing same-direction and
// 180-degree reversal requests.
module snake_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic           clk_i,
    input  logic           reset_i,
    snake_dir_ctrl_if.slave bus
);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       st;
    logic [3:0]       st_prev;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       fall;

    logic [1:0] cur_dir;
    logic [1:0] pend_dir;
    logic       pend_valid;
    logic [3:0] key_press;
    logic       reject;

    logic       cand_valid;
    logic [1:0] cand_dir;
    logic       commit;
    logic [1:0] eff_dir;
    logic [1:0] cur_dir_next;
    logic [1:0] pend_dir_next;
    logic       pend_valid_next;
    logic       reject_next;

    // Two-flop synchroniser per key, then a per-key stability counter that
    // only moves the accepted level after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sync1   <= 4'hF;
            sync2   <= 4'hF;
            st      <= 4'hF;
            st_prev <= 4'hF;
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            sync1   <= bus.key_ni;
            sync2   <= sync1;
            st_prev <= st;
            for (int k = 0; k < 4; k++) begin
                if (sync2[k] != st[k]) begin
                    if (cnt[k] == CNT_LAST) begin
                        st[k]  <= sync2[k];
                        cnt[k] <= '0;
                    end else begin
                        cnt[k] <= cnt[k] + CNT_W'(1);
                    end
                end else begin
                    cnt[k] <= '0;
                end
            end
        end
    end

    // A press is a released-to-pressed transition of the debounced level.
    assign fall = st_prev & ~st;

    // Pick one candidate by fixed priority, then apply step commit and the
    // accept/reject rule against the direction that will be in force after this step.
    always_comb begin
        cand_valid      = |fall;
        cand_dir        = DIR_RIGHT;
        commit          = bus.step_i & pend_valid & bus.enable_i;
        eff_dir         = cur_dir;
        cur_dir_next    = cur_dir;
        pend_dir_next   = pend_dir;
        pend_valid_next = pend_valid;
        reject_next     = 1'b0;

        if (fall[0]) begin
            cand_dir = DIR_RIGHT;
        end else if (fall[1]) begin
            cand_dir = DIR_DOWN;
        end else if (fall[2]) begin
            cand_dir = DIR_UP;
        end else if (fall[3]) begin
            cand_dir = DIR_LEFT;
        end

        if (commit) begin
            eff_dir = pend_dir;
        end

        if (!bus.enable_i) begin
            pend_valid_next = 1'b0;
        end else begin
            if (commit) begin
                cur_dir_next    = pend_dir;
                pend_valid_next = 1'b0;
            end
            if (cand_valid) begin
                if ((cand_dir != eff_dir) && (cand_dir != (eff_dir ^ 2'b10))) begin
                    pend_dir_next   = cand_dir;
                    pend_valid_next = 1'b1;
                end else begin
                    reject_next = 1'b1;
                end
            end
        end
    end

    // Register direction state and the one-cycle status pulses together so
    // key_press, pend_valid and reject all appear on the same cycle.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cur_dir    <= DIR_RIGHT;
            pend_dir   <= DIR_RIGHT;
            pend_valid <= 1'b0;
            key_press  <= 4'h0;
            reject     <= 1'b0;
        end else begin
            cur_dir    <= cur_dir_next;
            pend_dir   <= pend_dir_next;
            pend_valid <= pend_valid_next;
            key_press  <= fall;
            reject     <= reject_next;
        end
    end

    assign bus.dir_o        = cur_dir;
    assign bus.pend_valid_o = pend_valid;
    assign bus.key_press_o  = key_press;
    assign bus.reject_o     = reject;

endmodule

// File: doc/snake_dir_ctrl.md
# snake_dir_ctrl

Pushbutton front-end for the snake game: synchronises and debounces the four raw board pushbuttons and turns presses into a registered movement direction. The direction is committed only on the game-step tick, and 180° reversals are rejected. Sits between the board pushbutton pins and the game-logic core, which consumes `dir_o` and supplies `step_i`.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: cycles a synchronised key level must stay stable before it is accepted (10 ms at 50 MHz); legal range ≥ 2.
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk_i` in 1: single system clock (50 MHz on board).
- `reset_i` in 1: reset, synchronous, active-low.
- `key_ni` in 4: raw pushbuttons, active-low (0 = pressed), asynchronous to `clk_i`.
  - KEY0 = right, KEY1 = down, KEY2 = up, KEY3 = left.
- `enable_i` in 1: game running; presses and steps are ignored when low.
- `step_i` in 1: one-cycle pulse from the game core each time the snake advances.
- `dir_o` out 2: committed direction.
  - Encoding: 00 up, 01 right, 10 down, 11 left; opposite(d) = d ^ 2'b10.
- `pend_valid_o` out 1: a direction is buffered, waiting for the next step.
- `key_press_o` out 4: one-cycle pulse per key on each debounced press (released→pressed).
- `reject_o` out 1: one-cycle pulse when the selected press is discarded as same-direction or reversal.

## Operation
- **Synchroniser:** two flops per key. Reset value is 1 (released).
- **Debounce, per key:**
  - Keep a stable level `st[k]` (reset 1) and a counter (reset 0).
  - If sync ≠ `st[k]`: the counter increments.
    - When the counter equals DEBOUNCE_CYCLES−1 and sync still differs: `st[k]` ← sync and the counter ← 0.
  - If sync == `st[k]`: the counter ← 0, so any glitch restarts the count.
- **Press detect:** when `st[k]` goes 1→0, `key_press_o[k]` is driven high for exactly one cycle (registered). Release produces no pulse.
- **Candidate selection:** if several presses occur in the same cycle, a fixed priority picks one: KEY0 > KEY1 > KEY2 > KEY3. The others are dropped silently (no `reject_o`).
- **Effective direction:** `eff` = `pend_dir` if (`step_i` & `pend_valid` & `enable_i`), else `cur_dir`.
- **Accept rule (`enable_i` high):**
  - The candidate is accepted iff candidate ≠ `eff` and candidate ≠ opposite(`eff`).
  - Accepted: `pend_dir` ← candidate, `pend_valid` ← 1. The latest accepted press overwrites any earlier pending one.
  - Otherwise: pulse `reject_o`; pending state is unchanged.
- **Commit:** on `step_i` with `enable_i` high and `pend_valid` set, `cur_dir` ← `pend_dir` and `pend_valid` ← 0. An accept in that same cycle sets `pend_valid` again with the new candidate, which commits on the following step.
- **`enable_i` low:**
  - `pend_valid` ← 0; `step_i` is ignored; `cur_dir` holds.
  - `key_press_o` still pulses; `reject_o` stays low.
- **Reset values:**
  - `cur_dir` = 01 (right), `pend_dir` = 01, `pend_valid` = 0.
  - `key_press_o` = 0, `reject_o` = 0, all counters 0, all `st` = 1.
- Reset asserted mid-debounce or while pending discards all state on the next edge. A key held through reset release produces a press pulse once debounced.

## Timing
- Raw press to `key_press_o` pulse: exactly DEBOUNCE_CYCLES+3 rising edges for a clean edge (2 sync + DEBOUNCE_CYCLES stable + 1 output register).
- `key_press_o` to `pend_valid_o` / `reject_o`: same cycle (`pend_valid` and `reject_o` are registered from the same evaluation as `key_press_o`), i.e. both appear one cycle after `st` falls.
- `step_i` to `dir_o` update: `dir_o` changes on the edge that samples `step_i`, so it is visible the next cycle.
- All outputs are registered; no combinational input→output paths.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and CNT_W=3.
1. **Reset defaults:** hold `reset_i`=0 for 3 cycles, then release → `dir_o`=01, `pend_valid_o`=0, `key_press_o`=0000, `reject_o`=0.
2. **Debounce latency and glitch:**
   - Drive `key_ni[1]` low cleanly → `key_press_o`=0010 for one cycle exactly 7 edges later, then `pend_valid_o`=1.
   - A 3-cycle low glitch → no pulse.
3. **Commit on step:** after press down (10) with `enable_i`=1, pulse `step_i` → `dir_o`=10 next cycle, `pend_valid_o`=0. Without `step_i`, `dir_o` stays 01.
4. **Reversal rejection:** with `dir_o`=01, press left (KEY3) → `reject_o` pulses, `pend_valid_o` stays 0. Press right (KEY0) → `reject_o` pulses.
5. **Step/press collision:**
   - Setup: `dir_o`=00, `pend_dir`=01 pending.
   - Press left in the same cycle as `step_i` → `dir_o`=01, left rejected (opposite of `eff` 01).
   - Repeat with press down → `dir_o`=01, `pend_valid_o`=1 with `pend_dir`=10, committed on the next `step_i`.
6. **Priority and enable:**
   - KEY0 and KEY2 debounced in the same cycle → candidate is right (01); `key_press_o`=0101.
   - With `enable_i`=0: presses leave `dir_o` unchanged, `pend_valid_o` cleared, `reject_o`=0.
